mips_mem_responder: RTL and testbench

Unified instruction/data memory that answers the multi-cycle MIPS core's memory requests (MemRead/MemWrite, byte address, write data). It is the responder side of the core's memory interface. It returns read data in the same cycle and commits writes on the clock edge. After reset it runs a clear sweep, then accepts testbench program loading through a side port. It also keeps access counters and sticky error flags for debug.

---
 rtl/mips_mem_pkg.sv | 12 +
 rtl/mips_sat_counter.sv | 23 ++
 rtl/mips_mem_responder.sv | 128 ++++++++++++
 tb/tb_mips_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified memory responder.
package mips_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module mips_sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_inc,
  output logic [COUNT_W-1:0] o_count
);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory answering the multi-cycle MIPS core, with a
// post-reset clear sweep, a loader side port, access counters and sticky errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing one word per edge; core and loader are ignored
// ST_READY | serving core reads/writes and loader writes
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        adr,
  input  logic [31:0]        data_in,
  input  logic               MemRead,
  input  logic               MemWrite,
  output logic [31:0]        data_out,
  input  logic               ld_en,
  input  logic [31:0]        ld_adr,
  input  logic [31:0]        ld_data,
  output logic               ready,
  output logic               misalign_err,
  output logic               range_err,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] wr_count
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] LIMIT = WORD_W'(4 * DEPTH);

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic              r_misalign;
  logic              r_range;

  logic              w_ready_st;
  logic [IDX_W-1:0]  w_core_idx;
  logic [IDX_W-1:0]  w_ld_idx;
  logic              w_core_in_range;
  logic              w_ld_in_range;
  logic              w_core_acc;
  logic              w_ld_wr;
  logic              w_core_wr;
  logic              w_misalign_set;
  logic              w_range_set;

  assign w_ready_st      = (r_state == ST_READY);
  assign w_core_idx      = adr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign w_ld_idx        = ld_adr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
  // Full-width compares so that any high address bit marks the access out of range.
  assign w_core_in_range = (adr < LIMIT);
  assign w_ld_in_range   = (ld_adr < LIMIT);
  assign w_core_acc      = w_ready_st && (MemRead || MemWrite);
  assign w_ld_wr         = w_ready_st && ld_en && w_ld_in_range;
  assign w_core_wr       = w_ready_st && MemWrite && w_core_in_range && !w_ld_wr;
  assign w_misalign_set  = w_core_acc && (adr[BYTE_OFF_W-1:0] != '0);
  assign w_range_set     = w_ready_st &&
                           ((w_core_acc && !w_core_in_range) || (ld_en && !w_ld_in_range));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Loader wins over a same-cycle core write; the sweep owns the array while clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_ld_wr) begin
        r_mem[w_ld_idx] <= ld_data;
      end else if (w_core_wr) begin
        r_mem[w_core_idx] <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
      r_range    <= 1'b0;
    end else begin
      if (w_misalign_set) r_misalign <= 1'b1;
      if (w_range_set)    r_range    <= 1'b1;
    end
  end

  mips_sat_counter #(.COUNT_W(COUNT_W)) u_rd_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_ready_st && MemRead),
    .o_count (rd_count)
  );

  mips_sat_counter #(.COUNT_W(COUNT_W)) u_wr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_ready_st && MemWrite),
    .o_count (wr_count)
  );

  assign data_out     = (w_ready_st && MemRead && w_core_in_range) ? r_mem[w_core_idx] : '0;
  assign ready        = w_ready_st;
  assign misalign_err = r_misalign;
  assign range_err    = r_range;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder with a cycle-level behavioural model.
module tb_mips_mem_responder;

  localparam int D    = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   adr = '0;
  logic [31:0]   data_in = '0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [31:0]   data_out;
  logic          ld_en = 1'b0;
  logic [31:0]   ld_adr = '0;
  logic [31:0]   ld_data = '0;
  logic          ready;
  logic          misalign_err;
  logic          range_err;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  int total = 0;
  int bad   = 0;

  mips_mem_responder #(.DEPTH(D), .COUNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .adr          (adr),
    .data_in      (data_in),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .data_out     (data_out),
    .ld_en        (ld_en),
    .ld_adr       (ld_adr),
    .ld_data      (ld_data),
    .ready        (ready),
    .misalign_err (misalign_err),
    .range_err    (range_err),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, edges left in the sweep, counts, flags.
  bit          m_known = 0;
  bit          m_ready = 0;
  int          m_left  = 0;
  logic [31:0] m_mem [D];
  int          m_rd = 0;
  int          m_wr = 0;
  bit          m_mis = 0;
  bit          m_rng = 0;

  function automatic logic [31:0] exp_dout();
    if (m_ready && MemRead && (adr < 4 * D)) return m_mem[(adr / 4) % D];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    bit core_ok, ld_ok;
    core_ok = (adr < 4 * D);
    ld_ok   = (ld_adr < 4 * D);
    if (rst) begin
      m_known = 1;
      m_ready = 0;
      m_left  = D;
      m_rd = 0; m_wr = 0; m_mis = 0; m_rng = 0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < D; i++) m_mem[i] = 32'h0;
      end
    end else begin
      if (MemRead  && m_rd < CMAX) m_rd++;
      if (MemWrite && m_wr < CMAX) m_wr++;
      if ((MemRead || MemWrite) && (adr % 4 != 0)) m_mis = 1;
      if (((MemRead || MemWrite) && !core_ok) || (ld_en && !ld_ok)) m_rng = 1;
      if (ld_en && ld_ok)             m_mem[(ld_adr / 4) % D] = ld_data;
      else if (MemWrite && core_ok)   m_mem[(adr / 4) % D]    = data_in;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("m_data_out", data_out, exp_dout());
      chk("m_ready", {31'h0, ready}, {31'h0, m_ready});
      chk("m_misalign", {31'h0, misalign_err}, {31'h0, m_mis});
      chk("m_range", {31'h0, range_err}, {31'h0, m_rng});
      chk("m_rd_count", {28'h0, rd_count}, m_rd);
      chk("m_wr_count", {28'h0, wr_count}, m_wr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead = 0; MemWrite = 0; ld_en = 0;
    adr = '0; data_in = '0; ld_adr = '0; ld_data = '0;
  endtask

  // Counts edges from rst release until ready; optionally pokes a core write into edge 5.
  task automatic wait_ready(input bit poke);
    int n = 0;
    while (!ready && n < 100) begin
      if (poke && n == 4) begin
        MemWrite = 1; adr = 32'h0; data_in = 32'hFFFF_FFFF;
      end
      if (poke && n == 5) idle();
      tick();
      n++;
    end
    chk("ready_latency", n, D);
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_rd_count", {28'h0, rd_count}, 32'h0);
    rst = 0;
    wait_ready(1);
    chk("sweep_write_lost_wr_count", {28'h0, wr_count}, 32'h0);

    for (int i = 0; i < D; i++) begin
      adr = 32'(i * 4); MemRead = 1;
      #1 chk("sweep_read_zero", data_out, 32'h0);
      tick();
    end
    idle();

    rst = 1; tick(); tick(); rst = 0;
    wait_ready(0);

    ld_en = 1; ld_adr = 32'h8; ld_data = 32'hDEAD_BEEF;
    tick(); idle();
    MemRead = 1; adr = 32'h8;
    #1 chk("load_read", data_out, 32'hDEAD_BEEF);
    tick(); idle();
    chk("load_rd_count", {28'h0, rd_count}, 32'd1);

    ld_en = 1; ld_adr = 32'h4; ld_data = 32'h1111_1111;
    tick(); idle();
    MemRead = 1; MemWrite = 1; adr = 32'h4; data_in = 32'h2222_2222;
    #1 chk("rbw_old", data_out, 32'h1111_1111);
    tick(); idle();
    chk("rbw_rd_count", {28'h0, rd_count}, 32'd2);
    chk("rbw_wr_count", {28'h0, wr_count}, 32'd1);
    MemRead = 1; adr = 32'h4;
    #1 chk("rbw_new", data_out, 32'h2222_2222);
    tick(); idle();

    ld_en = 1; ld_adr = 32'hC; ld_data = 32'hA;
    MemWrite = 1; adr = 32'hC; data_in = 32'hB;
    tick(); idle();
    chk("conflict_wr_count", {28'h0, wr_count}, 32'd2);
    MemRead = 1; adr = 32'hC;
    #1 chk("conflict_loader_wins", data_out, 32'hA);
    tick(); idle();

    MemRead = 1; adr = 32'h6;
    #1 chk("misalign_read", data_out, 32'h2222_2222);
    tick(); idle();
    chk("misalign_flag", {31'h0, misalign_err}, 32'h1);
    chk("range_clear_before", {31'h0, range_err}, 32'h0);
    MemWrite = 1; adr = 32'h40; data_in = 32'h5555_5555;
    tick(); idle();
    chk("range_flag", {31'h0, range_err}, 32'h1);
    MemRead = 1; adr = 32'h0;
    #1 chk("range_no_alias", data_out, 32'h0);
    tick(); idle();
    MemRead = 1; adr = 32'h40;
    #1 chk("range_read_zero", data_out, 32'h0);
    tick(); idle();
    repeat (3) tick();
    chk("misalign_sticky", {31'h0, misalign_err}, 32'h1);
    chk("range_sticky", {31'h0, range_err}, 32'h1);

    MemRead = 1; adr = 32'h8;
    repeat (20) tick();
    chk("rd_saturated", {28'h0, rd_count}, 32'd15);

    rst = 1;
    tick();
    chk("midrst_ready", {31'h0, ready}, 32'h0);
    chk("midrst_rd_count", {28'h0, rd_count}, 32'h0);
    chk("midrst_wr_count", {28'h0, wr_count}, 32'h0);
    chk("midrst_misalign", {31'h0, misalign_err}, 32'h0);
    chk("midrst_range", {31'h0, range_err}, 32'h0);
    rst = 0; idle();
    wait_ready(0);
    MemRead = 1; adr = 32'h8;
    #1 chk("midrst_cleared", data_out, 32'h0);
    tick(); idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
